// File: rtl/mpadd_seq.sv
// Multi-precision add/subtract sequencer: processes WORDS-byte operands one byte per
// cycle, LSB first, through a single 8-bit adder slice with a registered carry.
module mpadd_seq #(
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sub,
    input  logic               cin,
    input  logic [8*WORDS-1:0] a,
    input  logic [8*WORDS-1:0] b,
    output logic               busy,
    output logic               done,
    output logic [8*WORDS-1:0] result,
    output logic               cout,
    output logic               ovf
);

    localparam int W  = 8 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          sub_q;
    logic          carry_q;

    logic [7:0] a_byte;
    logic [7:0] b_byte;
    logic [8:0] sum9;
    logic       c7;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        a_byte = a_q[{idx, 3'b000} +: 8];
        b_byte = b_q[{idx, 3'b000} +: 8];
        if (sub_q)
            b_byte = ~b_byte;
        sum9 = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, carry_q};
        // carry into the sign bit, recovered from the operand and sum bits
        c7   = a_byte[7] ^ b_byte[7] ^ sum9[7];
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            idx     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        sub_q   <= sub;
                        carry_q <= cin ^ sub;
                        idx     <= '0;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    result[{idx, 3'b000} +: 8] <= sum9[7:0];
                    carry_q <= sum9[8];
                    if (idx == LAST) begin
                        cout  <= sum9[8];
                        ovf   <= c7 ^ sum9[8];
                        state <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mpadd_seq.sv
// Self-checking bench for mpadd_seq (WORDS=4): directed corner cases plus random
// operations compared against a wide-arithmetic reference model.
module tb_mpadd_seq;

    localparam int WORDS = 4;
    localparam int W     = 8 * WORDS;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    mpadd_seq #(.WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin),
        .a(a), .b(b), .busy(busy), .done(done), .result(result),
        .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer arithmetic, then reduce to W bits and flags.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic ms, input logic mc,
                                  output logic [W-1:0] r, output logic co, output logic ov);
        longint ua = ma;
        longint ub = mb;
        longint sa = $signed(ma);
        longint sb = $signed(mb);
        longint cv = mc;
        longint u, s;
        u  = ms ? ua - ub - cv : ua + ub + cv;
        s  = ms ? sa - sb - cv : sa + sb + cv;
        r  = u[W-1:0];
        co = ms ? (ua >= ub + cv) : u[W];
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    // Drive operands and pulse start; returns at the first negedge after acceptance.
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                            input logic ts, input logic tc);
        @(negedge clk);
        a = ta; b = tbv; sub = ts; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; sub = $urandom_range(0, 1); cin = $urandom_range(0, 1);
    endtask

    task automatic wait_done(output int busy_cycles, output bit ok);
        busy_cycles = 0;
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (done) begin
                ok = 1'b1;
                return;
            end
            if (busy) busy_cycles++;
            @(negedge clk);
        end
        check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                          input logic ts, input logic tc);
        logic [W-1:0] er;
        logic eco, eov;
        int bc;
        bit ok;
        model(ta, tbv, ts, tc, er, eco, eov);
        start_op(ta, tbv, ts, tc);
        wait_done(bc, ok);
        if (ok) begin
            check({tag, "_result"}, 64'(result), 64'(er));
            check({tag, "_cout"}, 64'(cout), 64'(eco));
            check({tag, "_ovf"}, 64'(ovf), 64'(eov));
            check({tag, "_busy_cycles"}, 64'(bc), 64'(WORDS));
            check({tag, "_busy_in_done"}, 64'(busy), 64'd0);
            @(negedge clk);
            check({tag, "_done_pulse"}, 64'(done), 64'd0);
            check({tag, "_result_hold"}, 64'(result), 64'(er));
        end
    endtask

    initial begin
        logic [W-1:0] er;
        logic eco, eov;
        int bc, gap, extra;
        bit ok;

        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op("add_povf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op("add_novf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
        run_op("sub_pos",  32'd5, 32'd3, 1'b1, 1'b0);
        run_op("sub_neg",  32'd3, 32'd5, 1'b1, 1'b0);
        run_op("sub_ovf",  32'h8000_0000, 32'd1, 1'b1, 1'b0);
        run_op("sub_bin",  32'd5, 32'd5, 1'b1, 1'b1);
        run_op("chain",    32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b1);

        for (int i = 0; i < 20; i++)
            run_op("rand", $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // start pulsed during RUN with other operands must be ignored
        model(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, er, eco, eov);
        start_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(bc, ok);
        if (ok) begin
            check("ign_result", 64'(result), 64'(er));
            extra = 0;
            for (int n = 0; n < 10; n++) begin
                @(negedge clk);
                if (done) extra++;
            end
            check("ign_single_done", 64'(extra), 64'd0);
        end

        // start held high: back-to-back operations every WORDS+2 cycles
        model(32'hA5A5_0F0F, 32'h5A5A_F0F1, 1'b0, 1'b1, er, eco, eov);
        @(negedge clk);
        a = 32'hA5A5_0F0F; b = 32'h5A5A_F0F1; sub = 1'b0; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        wait_done(bc, ok);
        for (int k = 0; k < 2 && ok; k++) begin
            check("b2b_result", 64'(result), 64'(er));
            check("b2b_cout", 64'(cout), 64'(eco));
            @(negedge clk);
            gap = 1;
            wait_done(bc, ok);
            gap += bc + 1;
            if (ok) check("b2b_period", 64'(gap), 64'(WORDS + 2));
        end
        start = 1'b0;
        repeat (WORDS + 3) @(negedge clk);

        // reset during the 2nd RUN cycle aborts without a done pulse
        run_op("pre_rst", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
        start_op(32'h0102_0304, 32'h1111_1111, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_result", 64'(result), 64'd0);
        check("arst_cout", 64'(cout), 64'd0);
        check("arst_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        check("arst_no_done", 64'(extra), 64'd0);
        run_op("post_rst", 32'hFEDC_BA98, 32'h0123_4567, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
